error_log_ctrl: RTL and testbench
=================================

ERROR_LOG_CTRL -- requirements
Module: error_log_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 16, max cycles in FLUSH_RUN before the table's valid output is first seen high.
REQ-002 SHALL have parameter TABLE_DEPTH, default 8, number of entries the downstream error table holds.
REQ-003 sysClk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cam_err_req  in  1  camera error request, level, held until ack.
REQ-006 cam_err_index  in  16  image/frame index of camera error.
REQ-007 cam_err_camid  in  1  camera id.
REQ-008 cam_err_code  in  3  {timeout, img_cap_failure, cam_not_detected}.
REQ-009 cam_err_ack  out  1  one-cycle grant pulse.
REQ-010 flash_err_req  in  1  flash error request, level, held until ack.
REQ-011 flash_err_index  in  16  flash page/sector index.
REQ-012 flash_err_code  in  3  {write_failure, read_failure, erase_failure}.
REQ-013 flash_err_ack  out  1  one-cycle grant pulse.
REQ-014 flush_req  in  1  single-cycle host flush command.
REQ-015 flush_busy  out  1  high in FLUSH_RUN and DONE.
REQ-016 flush_done  out  1  one-cycle completion pulse.
REQ-017 tbl_index  out  16 / tbl_camid  out  1 / tbl_flags  out  6  entry fields to table, tbl_flags = {cam_err_code, flash_err_code}, MSB first.
REQ-018 tbl_valid  out  1  one-cycle entry write strobe.
REQ-019 tbl_flush  out  1  table flush enable, level.
REQ-020 tbl_out_valid  in  1  valid output returned by the table.
REQ-021 log_count  out  4  entries written since last flush, saturates at TABLE_DEPTH.
REQ-022 overflow_cnt  out  8  entries written while log_count = TABLE_DEPTH, saturates at 255.

Function
REQ-023 FSM states SHALL be IDLE, GRANT, FLUSH_RUN, DONE.
REQ-024 In IDLE with flush_req or pending_flush set, the FSM SHALL go to FLUSH_RUN; flush takes priority over error requests.
REQ-025 Otherwise, in IDLE with any request high, the FSM SHALL go to GRANT and select one source by round-robin: both high -> source not last granted; last-granted resets to flash, so camera wins first.
REQ-026 In GRANT (exactly one cycle), the FSM SHALL pulse the selected ack, drive tbl_index/tbl_camid/tbl_flags from that source (the other source's flag bits 0, tbl_camid 0 for flash), pulse tbl_valid, then return to IDLE.
REQ-027 A granted request with code = 3'b000 SHALL be acked with no tbl_valid and no counter change.
REQ-028 Per written entry, log_count SHALL increment if < TABLE_DEPTH, else overflow_cnt SHALL increment (saturating); the entry is still written.
REQ-029 Grant throughput SHALL be one entry per 2 cycles; a request is acked no earlier than 1 cycle after it is first seen in IDLE.
REQ-030 flush_req arriving in GRANT SHALL set pending_flush; flush_req in FLUSH_RUN/DONE SHALL be ignored.
REQ-031 In FLUSH_RUN, tbl_flush SHALL be high, and no acks SHALL be issued; requests SHALL wait.
REQ-032 FLUSH_RUN SHALL exit to DONE on the first cycle tbl_out_valid is low after having been seen high, or when FLUSH_TIMEOUT cycles elapse without it being seen high.
REQ-033 DONE (one cycle) SHALL drive tbl_flush low, pulse flush_done, and clear log_count, overflow_cnt and pending_flush; next state IDLE.
REQ-034 Fields tbl_index/tbl_camid/tbl_flags SHALL hold last value outside GRANT.

Reset
REQ-035 On rst high, state SHALL be IDLE; all outputs, counters, pending_flush and the flush timer SHALL be 0; last-granted SHALL be flash.
REQ-036 rst mid-flush SHALL deassert tbl_flush immediately (asynchronously) and issue no flush_done.

Verification
REQ-037 cam req (index 0x0012, camid 1, code 3'b100) -> ack 1 cycle later, tbl_valid pulse, tbl_index 0x0012, tbl_flags 6'b100000, log_count 1.
REQ-038 cam and flash req held together 4 grants -> acks alternate cam, flash, cam, flash; one every 2 cycles.
REQ-039 10 entries written -> log_count 8, overflow_cnt 2; flush -> both 0 after flush_done.
REQ-040 flush_req during GRANT with cam req pending -> GRANT completes, FLUSH_RUN next, cam ack withheld until after flush_done.
REQ-041 flush with tbl_out_valid held 0 -> flush_done exactly FLUSH_TIMEOUT+1 cycles after entering FLUSH_RUN; tbl_out_valid high 3 cycles then low -> DONE on the falling cycle.
REQ-042 rst asserted while in FLUSH_RUN -> tbl_flush 0 at once, no flush_done, counters 0.

Source files
------------

// File: rtl/error_log_ctrl_if.sv
// Signal bundle between error_log_ctrl and its surroundings.
// It covers the camera and flash error sources, the host flush command
// and the downstream error table.
// The controller uses the master modport.
// The bench or the surrounding logic uses the slave modport.
interface error_log_ctrl_if;
    // camera error source
    logic        cam_err_req;
    logic [15:0] cam_err_index;
    logic        cam_err_camid;
    logic [2:0]  cam_err_code;
    logic        cam_err_ack;

    // flash error source
    logic        flash_err_req;
    logic [15:0] flash_err_index;
    logic [2:0]  flash_err_code;
    logic        flash_err_ack;

    // host flush command
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;

    // downstream error table
    logic [15:0] tbl_index;
    logic        tbl_camid;
    logic [5:0]  tbl_flags;
    logic        tbl_valid;
    logic        tbl_flush;
    logic        tbl_out_valid;

    // logging statistics
    logic [3:0]  log_count;
    logic [7:0]  overflow_cnt;

    modport master (
        input  cam_err_req, cam_err_index, cam_err_camid, cam_err_code,
        output cam_err_ack,
        input  flash_err_req, flash_err_index, flash_err_code,
        output flash_err_ack,
        input  flush_req,
        output flush_busy, flush_done,
        output tbl_index, tbl_camid, tbl_flags, tbl_valid, tbl_flush,
        input  tbl_out_valid,
        output log_count, overflow_cnt
    );

    modport slave (
        output cam_err_req, cam_err_index, cam_err_camid, cam_err_code,
        input  cam_err_ack,
        output flash_err_req, flash_err_index, flash_err_code,
        input  flash_err_ack,
        output flush_req,
        input  flush_busy, flush_done,
        input  tbl_index, tbl_camid, tbl_flags, tbl_valid, tbl_flush,
        output tbl_out_valid,
        input  log_count, overflow_cnt
    );
endinterface

// File: rtl/error_log_ctrl.sv
// error_log_ctrl: arbitrates camera/flash error reports into a downstream
// error table, counts logged and overflowed entries, and sequences host
// table flushes.
// All outputs are registered.
// A grant is decided in IDLE and its ack, write strobe and entry fields are
// loaded on the edge that enters GRANT, so they are visible for exactly the
// single GRANT cycle.
module error_log_ctrl #(
    parameter int FLUSH_TIMEOUT = 16,
    parameter int TABLE_DEPTH   = 8
) (
    input  logic             sysClk,
    input  logic             rst,
    error_log_ctrl_if.master bus
);

    // timer must be able to hold FLUSH_TIMEOUT itself
    localparam int               TMR_W    = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLUSH_TIMEOUT);
    localparam logic [3:0]       DEPTH_C  = 4'(TABLE_DEPTH);
    localparam logic [7:0]       OVF_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT     = 2'b01,
        FLUSH_RUN = 2'b10,
        DONE      = 2'b11
    } state_t;

    // Table flag layout is {camera code, flash code}; the unused half is zero.
    function automatic logic [5:0] pack_flags(input logic is_cam, input logic [2:0] code);
        logic [5:0] flags;
        if (is_cam) begin
            flags = {code, 3'b000};
        end else begin
            flags = {3'b000, code};
        end
        return flags;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic              last_cam_r;       // 1: camera was granted last, 0: flash
    logic              pending_flush_r;
    logic              seen_r;           // tbl_out_valid observed high during this flush
    logic [TMR_W-1:0]  timer_r;

    logic              sel_cam_s;
    logic [2:0]        sel_code_s;
    logic [15:0]       sel_index_s;
    logic              sel_camid_s;
    logic              grant_s;
    logic              write_s;
    logic              flush_exit_s;
    logic              done_entry_s;

    logic              cam_ack_r;
    logic              flash_ack_r;
    logic              tbl_valid_r;
    logic [15:0]       tbl_index_r;
    logic              tbl_camid_r;
    logic [5:0]        tbl_flags_r;
    logic              tbl_flush_r;
    logic              flush_busy_r;
    logic              flush_done_r;
    logic [3:0]        log_count_r;
    logic [7:0]        overflow_cnt_r;

    // Round-robin pick: camera wins unless flash also requests and camera went last.
    always_comb begin
        sel_cam_s = 1'b0;
        if (bus.cam_err_req && (!bus.flash_err_req || !last_cam_r)) begin
            sel_cam_s = 1'b1;
        end else begin
            sel_cam_s = 1'b0;
        end
    end

    // Multiplex the fields of the selected source.
    always_comb begin
        sel_code_s  = 3'b000;
        sel_index_s = 16'h0000;
        sel_camid_s = 1'b0;
        if (sel_cam_s) begin
            sel_code_s  = bus.cam_err_code;
            sel_index_s = bus.cam_err_index;
            sel_camid_s = bus.cam_err_camid;
        end else begin
            sel_code_s  = bus.flash_err_code;
            sel_index_s = bus.flash_err_index;
            sel_camid_s = 1'b0;
        end
    end

    // Flush ends on the first low table-valid after it was seen high.
    // It also ends on timeout if the table valid never rose.
    always_comb begin
        flush_exit_s = 1'b0;
        if (bus.tbl_out_valid) begin
            flush_exit_s = 1'b0;
        end else if (seen_r) begin
            flush_exit_s = 1'b1;
        end else if (timer_r == TMR_LAST) begin
            flush_exit_s = 1'b1;
        end else begin
            flush_exit_s = 1'b0;
        end
    end

    // Next-state decode; flush requests outrank error requests in IDLE.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.flush_req || pending_flush_r) begin
                    next_state_s = FLUSH_RUN;
                end else if (bus.cam_err_req || bus.flash_err_req) begin
                    next_state_s = GRANT;
                    grant_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT: begin
                next_state_s = IDLE;
            end
            FLUSH_RUN: begin
                if (flush_exit_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FLUSH_RUN;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // A zero error code is acknowledged but never written to the table.
    assign write_s      = grant_s && (sel_code_s != 3'b000);
    assign done_entry_s = (state_r == FLUSH_RUN) && flush_exit_s;

    // State register.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Remember the last granted source; reset favours camera for the first tie.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            last_cam_r <= 1'b0;
        end else if (grant_s) begin
            last_cam_r <= sel_cam_s;
        end else begin
            last_cam_r <= last_cam_r;
        end
    end

    // A flush request that lands during GRANT is parked until IDLE.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            pending_flush_r <= 1'b0;
        end else if ((state_r == GRANT) && bus.flush_req) begin
            pending_flush_r <= 1'b1;
        end else if (done_entry_s) begin
            pending_flush_r <= 1'b0;
        end else begin
            pending_flush_r <= pending_flush_r;
        end
    end

    // Flush timer and table-valid tracking; both restart on every flush.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            timer_r <= '0;
            seen_r  <= 1'b0;
        end else if (state_r != FLUSH_RUN) begin
            timer_r <= '0;
            seen_r  <= 1'b0;
        end else begin
            seen_r <= seen_r | bus.tbl_out_valid;
            if (timer_r != TMR_LAST) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Entry counters: fill up to the table depth, then count overflows.
    // Both counters clear when the flush completes.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            log_count_r    <= 4'd0;
            overflow_cnt_r <= 8'd0;
        end else if (done_entry_s) begin
            log_count_r    <= 4'd0;
            overflow_cnt_r <= 8'd0;
        end else if (write_s) begin
            if (log_count_r < DEPTH_C) begin
                log_count_r <= log_count_r + 4'd1;
            end else if (overflow_cnt_r != OVF_MAX) begin
                overflow_cnt_r <= overflow_cnt_r + 8'd1;
            end else begin
                overflow_cnt_r <= overflow_cnt_r;
            end
        end else begin
            log_count_r    <= log_count_r;
            overflow_cnt_r <= overflow_cnt_r;
        end
    end

    // Registered handshake, table and flush-status outputs.
    // Entry fields hold their value outside a grant.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            cam_ack_r    <= 1'b0;
            flash_ack_r  <= 1'b0;
            tbl_valid_r  <= 1'b0;
            tbl_index_r  <= 16'h0000;
            tbl_camid_r  <= 1'b0;
            tbl_flags_r  <= 6'b000000;
            tbl_flush_r  <= 1'b0;
            flush_busy_r <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            cam_ack_r    <= grant_s && sel_cam_s;
            flash_ack_r  <= grant_s && !sel_cam_s;
            tbl_valid_r  <= write_s;
            tbl_flush_r  <= (next_state_s == FLUSH_RUN);
            flush_busy_r <= (next_state_s == FLUSH_RUN) || (next_state_s == DONE);
            flush_done_r <= done_entry_s;
            if (grant_s) begin
                tbl_index_r <= sel_index_s;
                tbl_camid_r <= sel_camid_s;
                tbl_flags_r <= pack_flags(sel_cam_s, sel_code_s);
            end else begin
                tbl_index_r <= tbl_index_r;
                tbl_camid_r <= tbl_camid_r;
                tbl_flags_r <= tbl_flags_r;
            end
        end
    end

    assign bus.cam_err_ack   = cam_ack_r;
    assign bus.flash_err_ack = flash_ack_r;
    assign bus.tbl_valid     = tbl_valid_r;
    assign bus.tbl_index     = tbl_index_r;
    assign bus.tbl_camid     = tbl_camid_r;
    assign bus.tbl_flags     = tbl_flags_r;
    assign bus.tbl_flush     = tbl_flush_r;
    assign bus.flush_busy    = flush_busy_r;
    assign bus.flush_done    = flush_done_r;
    assign bus.log_count     = log_count_r;
    assign bus.overflow_cnt  = overflow_cnt_r;

endmodule

// File: tb/tb_error_log_ctrl.sv
// Self-checking bench for error_log_ctrl.
// Directed stimulus pushes expected output events (acks, flush_done) into a
// queue, together with the cycle on which each event must appear.
// A monitor pops that queue and compares whenever the DUT shows an event.
module tb_error_log_ctrl;

    localparam int FT = 16;
    localparam int TD = 8;

    localparam logic [2:0] K_CAM   = 3'b100;
    localparam logic [2:0] K_FLASH = 3'b010;
    localparam logic [2:0] K_DONE  = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        int          at;
        logic        vld;
        logic [15:0] idx;
        logic        camid;
        logic [5:0]  flags;
        logic [3:0]  log_c;
        logic [7:0]  ovf_c;
    } exp_t;

    logic sysClk = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   m_log  = 0;
    int   m_ovf  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    error_log_ctrl_if bus();

    error_log_ctrl #(.FLUSH_TIMEOUT(FT), .TABLE_DEPTH(TD)) dut (
        .sysClk (sysClk),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        forever #5 sysClk = ~sysClk;
    end

    always @(posedge sysClk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total = total + 1;
        if (act !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Queue one expected event.
    // The small count model advances here: written entries fill log_count up
    // to TD and then overflow_cnt; a flush completion clears both.
    task automatic push(input logic [2:0] kind, input int at, input logic vld,
                        input logic [15:0] idx, input logic camid, input logic [5:0] flags);
        exp_t e;
        if (kind == K_DONE) begin
            m_log = 0;
            m_ovf = 0;
        end else if (vld) begin
            if (m_log < TD) m_log = m_log + 1;
            else if (m_ovf < 255) m_ovf = m_ovf + 1;
        end
        e.kind  = kind;
        e.at    = at;
        e.vld   = vld;
        e.idx   = idx;
        e.camid = camid;
        e.flags = flags;
        e.log_c = 4'(m_log);
        e.ovf_c = 8'(m_ovf);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysClk);
        #1;
    endtask

    task automatic do_cam(input logic [15:0] idx, input logic camid, input logic [2:0] code);
        bus.cam_err_index = idx;
        bus.cam_err_camid = camid;
        bus.cam_err_code  = code;
        bus.cam_err_req   = 1'b1;
        push(K_CAM, cyc + 1, code != 3'b000, idx, camid, {code, 3'b000});
        tick(1);
        bus.cam_err_req = 1'b0;
        tick(1);
    endtask

    task automatic do_flash(input logic [15:0] idx, input logic [2:0] code);
        bus.flash_err_index = idx;
        bus.flash_err_code  = code;
        bus.flash_err_req   = 1'b1;
        push(K_FLASH, cyc + 1, code != 3'b000, idx, 1'b0, {3'b000, code});
        tick(1);
        bus.flash_err_req = 1'b0;
        tick(1);
    endtask

    // Monitor: every ack / flush_done / tbl_valid cycle must match the queue head.
    initial begin
        forever begin
            @(negedge sysClk);
            if (!rst && (bus.cam_err_ack || bus.flash_err_ack || bus.flush_done || bus.tbl_valid)) begin
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_event: got cam_ack=%0b flash_ack=%0b done=%0b valid=%0b want no event (cycle %0d)",
                             bus.cam_err_ack, bus.flash_err_ack, bus.flush_done, bus.tbl_valid, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", 32'({bus.cam_err_ack, bus.flash_err_ack, bus.flush_done}), 32'(mon_e.kind));
                    chk("event_cycle", cyc, mon_e.at);
                    chk("tbl_valid", 32'(bus.tbl_valid), 32'(mon_e.vld));
                    if (mon_e.vld) begin
                        chk("tbl_index", 32'(bus.tbl_index), 32'(mon_e.idx));
                        chk("tbl_camid", 32'(bus.tbl_camid), 32'(mon_e.camid));
                        chk("tbl_flags", 32'(bus.tbl_flags), 32'(mon_e.flags));
                    end
                    chk("log_count", 32'(bus.log_count), 32'(mon_e.log_c));
                    chk("overflow_cnt", 32'(bus.overflow_cnt), 32'(mon_e.ovf_c));
                end
            end
        end
    end

    initial begin
        int c;
        bus.cam_err_req     = 1'b0;
        bus.cam_err_index   = 16'h0000;
        bus.cam_err_camid   = 1'b0;
        bus.cam_err_code    = 3'b000;
        bus.flash_err_req   = 1'b0;
        bus.flash_err_index = 16'h0000;
        bus.flash_err_code  = 3'b000;
        bus.flush_req       = 1'b0;
        bus.tbl_out_valid   = 1'b0;

        repeat (3) @(posedge sysClk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_log_count", 32'(bus.log_count), 0);
        chk("rst_overflow_cnt", 32'(bus.overflow_cnt), 0);
        chk("rst_tbl_flush", 32'(bus.tbl_flush), 0);
        chk("rst_flush_busy", 32'(bus.flush_busy), 0);
        chk("rst_tbl_index", 32'(bus.tbl_index), 0);
        chk("rst_tbl_flags", 32'(bus.tbl_flags), 0);
        tick(1);

        // single camera entry
        do_cam(16'h0012, 1'b1, 3'b100);

        // zero code: acked, not written
        do_flash(16'h0400, 3'b000);

        // both held: camera, flash, camera, flash, one every 2 cycles
        c = cyc;
        bus.cam_err_index   = 16'h0A01;
        bus.cam_err_camid   = 1'b0;
        bus.cam_err_code    = 3'b010;
        bus.flash_err_index = 16'h0B02;
        bus.flash_err_code  = 3'b001;
        bus.cam_err_req     = 1'b1;
        bus.flash_err_req   = 1'b1;
        push(K_CAM,   c + 1, 1'b1, 16'h0A01, 1'b0, 6'b010000);
        push(K_FLASH, c + 3, 1'b1, 16'h0B02, 1'b0, 6'b000001);
        push(K_CAM,   c + 5, 1'b1, 16'h0A01, 1'b0, 6'b010000);
        push(K_FLASH, c + 7, 1'b1, 16'h0B02, 1'b0, 6'b000001);
        tick(7);
        bus.cam_err_req   = 1'b0;
        bus.flash_err_req = 1'b0;
        tick(1);

        // fill past the table depth: 10 written entries in total
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) do_cam(16'(16'h0100 + i), 1'(i % 2), 3'b001);
            else            do_flash(16'(16'h0200 + i), 3'b010);
        end
        chk("fill_log_count", 32'(bus.log_count), 8);
        chk("fill_overflow_cnt", 32'(bus.overflow_cnt), 2);

        // flush with table valid held low: timeout path; camera waits
        c = cyc;
        bus.flush_req = 1'b1;
        tick(1);
        bus.flush_req = 1'b0;
        chk("run_tbl_flush", 32'(bus.tbl_flush), 1);
        chk("run_flush_busy", 32'(bus.flush_busy), 1);
        push(K_DONE, c + FT + 2, 1'b0, 16'h0000, 1'b0, 6'b000000);
        tick(2);
        bus.cam_err_index = 16'h0333;
        bus.cam_err_camid = 1'b1;
        bus.cam_err_code  = 3'b010;
        bus.cam_err_req   = 1'b1;
        push(K_CAM, c + FT + 4, 1'b1, 16'h0333, 1'b1, 6'b010000);
        tick(2);
        bus.flush_req = 1'b1;           // ignored while flushing
        tick(1);
        bus.flush_req = 1'b0;
        chk("run_tbl_flush_hold", 32'(bus.tbl_flush), 1);
        tick(FT + 4 - 6);
        bus.cam_err_req = 1'b0;
        tick(1);
        chk("after_done_tbl_flush", 32'(bus.tbl_flush), 0);

        // flush requested during GRANT; second camera request waits
        c = cyc;
        bus.cam_err_index = 16'h0444;
        bus.cam_err_camid = 1'b0;
        bus.cam_err_code  = 3'b001;
        bus.cam_err_req   = 1'b1;
        push(K_CAM, c + 1, 1'b1, 16'h0444, 1'b0, 6'b001000);
        tick(1);
        bus.flush_req = 1'b1;
        tick(1);
        bus.flush_req = 1'b0;
        push(K_DONE, c + 8, 1'b0, 16'h0000, 1'b0, 6'b000000);
        push(K_CAM, c + 10, 1'b1, 16'h0444, 1'b0, 6'b001000);
        tick(1);
        chk("pend_tbl_flush", 32'(bus.tbl_flush), 1);
        tick(1);
        bus.tbl_out_valid = 1'b1;
        tick(3);
        bus.tbl_out_valid = 1'b0;
        tick(3);
        bus.cam_err_req = 1'b0;
        tick(1);

        // reset in the middle of a flush
        bus.flush_req = 1'b1;
        tick(1);
        bus.flush_req = 1'b0;
        tick(2);
        chk("pre_rst_tbl_flush", 32'(bus.tbl_flush), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tbl_flush", 32'(bus.tbl_flush), 0);
        chk("async_rst_flush_busy", 32'(bus.flush_busy), 0);
        chk("async_rst_log_count", 32'(bus.log_count), 0);
        chk("async_rst_overflow_cnt", 32'(bus.overflow_cnt), 0);
        chk("async_rst_flush_done", 32'(bus.flush_done), 0);
        m_log = 0;
        m_ovf = 0;
        tick(2);
        rst = 1'b0;
        tick(FT + 4);

        // after reset, ties start with camera again
        c = cyc;
        bus.cam_err_index   = 16'h0555;
        bus.cam_err_camid   = 1'b1;
        bus.cam_err_code    = 3'b100;
        bus.flash_err_index = 16'h0666;
        bus.flash_err_code  = 3'b100;
        bus.cam_err_req     = 1'b1;
        bus.flash_err_req   = 1'b1;
        push(K_CAM,   c + 1, 1'b1, 16'h0555, 1'b1, 6'b100000);
        push(K_FLASH, c + 3, 1'b1, 16'h0666, 1'b0, 6'b000100);
        tick(3);
        bus.cam_err_req   = 1'b0;
        bus.flash_err_req = 1'b0;
        tick(1);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("scoreboard_left", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
